// File: rtl/intt_gs_butterfly_if.sv
// Sample bus for the inverse-NTT Gentleman-Sande butterfly.
// The source drives operands and stall enable; the butterfly returns u/v.
interface intt_gs_butterfly_if;
    logic        en;
    logic        valid_in;
    logic        mod_in;
    logic [24:0] a;
    logic [24:0] b;
    logic [24:0] w;
    logic        valid_out;
    logic        mod_out;
    logic [24:0] u;
    logic [24:0] v;

    modport master (
        output en, valid_in, mod_in, a, b, w,
        input  valid_out, mod_out, u, v
    );

    modport slave (
        input  en, valid_in, mod_in, a, b, w,
        output valid_out, mod_out, u, v
    );
endinterface

// File: rtl/intt_gs_butterfly.sv
// 4-stage Gentleman-Sande butterfly: u = a+b, v = (a-b)*w, mod q24 or q25.
// Modulus select rides with each sample; en stalls every register.
module intt_gs_butterfly #(
    parameter int LAT = 4
) (
    input logic              clk,
    input logic              rst_n,
    intt_gs_butterfly_if.slave io
);

    localparam logic [24:0] Q24 = 25'd16515073;
    localparam logic [24:0] Q25 = 25'd33292289;

    // Fold p = hi*2^k + lo into hi*(2^18-1) + lo; five folds give < 2q.
    function automatic logic [26:0] fold(input logic [49:0] p,
                                         input logic m24);
        logic [50:0] x;
        logic [50:0] hi;
        logic [50:0] lo;
        x = {1'b0, p};
        for (int i = 0; i < 5; i++) begin
            hi = m24 ? (x >> 24) : (x >> 25);
            lo = m24 ? {27'b0, x[23:0]} : {26'b0, x[24:0]};
            x  = (hi << 18) - hi + lo;
        end
        return 27'(x);
    endfunction

    logic [LAT-1:0] vld;
    logic [LAT-1:0] md;
    logic [24:0]    s1, d1, w1;
    logic [24:0]    s2, s3;
    logic [49:0]    p2;
    logic [26:0]    r3;
    logic [24:0]    u4, v4;

    logic [24:0]    q_in, q3;
    logic [25:0]    sum;
    logic [24:0]    dif;
    logic [24:0]    s_n, d_n, v_n;
    logic [26:0]    r_a;
    logic [26:0]    r_n;

    always_comb begin
        q_in = io.mod_in ? Q24 : Q25;
        sum  = {1'b0, io.a} + {1'b0, io.b};
        s_n  = (sum >= {1'b0, q_in}) ? 25'(sum - {1'b0, q_in})
                                     : sum[24:0];
        dif  = io.a - io.b;
        d_n  = (io.a < io.b) ? dif + q_in : dif;

        r_n  = fold(p2, md[1]);

        q3   = md[2] ? Q24 : Q25;
        r_a  = (r3 >= {1'b0, q3, 1'b0}) ? r3 - {1'b0, q3, 1'b0} : r3;
        v_n  = (r_a >= {2'b0, q3}) ? 25'(r_a - {2'b0, q3})
                                   : r_a[24:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            md  <= '0;
            s1  <= '0;
            d1  <= '0;
            w1  <= '0;
            s2  <= '0;
            p2  <= '0;
            s3  <= '0;
            r3  <= '0;
            u4  <= '0;
            v4  <= '0;
        end else if (io.en) begin
            vld <= {vld[LAT-2:0], io.valid_in};
            md  <= {md[LAT-2:0], io.mod_in};
            s1  <= s_n;
            d1  <= d_n;
            w1  <= io.w;
            s2  <= s1;
            p2  <= d1 * w1;
            s3  <= s2;
            r3  <= r_n;
            u4  <= s3;
            v4  <= v_n;
        end
    end

    assign io.valid_out = vld[LAT-1];
    assign io.mod_out   = md[LAT-1];
    assign io.u         = u4;
    assign io.v         = v4;

endmodule
